// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared constants, state and trap encodings for the copperv control unit
package control_unit_pkg;

  localparam int INST_TYPE_WIDTH = 3;

  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_IMM     = 3'd1;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_IMM = 3'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_REG = 3'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_BRANCH  = 3'd4;

  typedef enum logic [2:0] {
    CU_STATE_IDLE       = 3'd0,
    CU_STATE_FETCH_ADDR = 3'd1,
    CU_STATE_FETCH_DATA = 3'd2,
    CU_STATE_DECODE     = 3'd3,
    CU_STATE_EXEC       = 3'd4,
    CU_STATE_TRAP       = 3'd5
  } cu_state_t;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'd0,
    TRAP_ILLEGAL = 2'd1,
    TRAP_TIMEOUT = 2'd2
  } trap_cause_t;

  localparam logic PC_NEXT_PLUS4 = 1'b0;
  localparam logic PC_NEXT_IMM   = 1'b1;
  localparam logic RD_DIN_ALU    = 1'b0;
  localparam logic RD_DIN_IMM    = 1'b1;
  localparam logic ALU_SRC_RS2   = 1'b0;
  localparam logic ALU_SRC_IMM   = 1'b1;

  // Only the four assigned codes are executable; everything else traps.
  function automatic logic inst_type_legal(input logic [INST_TYPE_WIDTH-1:0] t);
    return (t == INST_TYPE_IMM) || (t == INST_TYPE_INT_IMM) ||
           (t == INST_TYPE_INT_REG) || (t == INST_TYPE_BRANCH);
  endfunction

endpackage

// File: rtl/control_unit_wait_timer.sv
// rtl/control_unit_wait_timer.sv - fetch wait counter that flags expiry after LIMIT cycles in a fetch state
module control_unit_wait_timer #(
  parameter int unsigned LIMIT = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  // Index of the last allowed wait cycle; LIMIT=0 disables expiry entirely.
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] r_count;

  // Count cycles spent in the current fetch state, parking at the last index.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (LIMIT != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle fetch/decode/execute sequencer with retire counter and trap handling
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH   = 32,
  parameter int unsigned FETCH_TIMEOUT = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_ir_addr_valid,
  input  logic                       i_ir_addr_ready,
  input  logic                       i_ir_data_valid,
  output logic                       o_ir_data_ready,
  output logic                       o_ld_inst,
  input  logic [INST_TYPE_WIDTH-1:0] i_inst_type,
  input  logic                       i_branch_taken,
  output logic                       o_rs1_en,
  output logic                       o_rs2_en,
  output logic                       o_rd_en,
  output logic                       o_alu_src_sel,
  output logic                       o_rd_din_sel,
  output logic                       o_pc_en,
  output logic                       o_pc_next_sel,
  output logic                       o_retired,
  output logic [COUNT_WIDTH-1:0]     o_retire_count,
  output logic                       o_trap,
  output logic [1:0]                 o_trap_cause
);

  cu_state_t              r_state;
  cu_state_t              w_next_state;
  trap_cause_t            r_trap_cause;
  trap_cause_t            w_trap_cause_next;
  logic [COUNT_WIDTH-1:0] r_retire_count;

  logic w_in_fetch;
  logic w_handshake;
  logic w_expired;
  logic w_is_imm;
  logic w_is_int_imm;
  logic w_is_int_reg;
  logic w_is_branch;

  assign w_is_imm     = (i_inst_type == INST_TYPE_IMM);
  assign w_is_int_imm = (i_inst_type == INST_TYPE_INT_IMM);
  assign w_is_int_reg = (i_inst_type == INST_TYPE_INT_REG);
  assign w_is_branch  = (i_inst_type == INST_TYPE_BRANCH);

  // Timer runs only in fetch states and restarts whenever a fetch handshake moves us on.
  assign w_in_fetch  = (r_state == CU_STATE_FETCH_ADDR) || (r_state == CU_STATE_FETCH_DATA);
  assign w_handshake = ((r_state == CU_STATE_FETCH_ADDR) && i_ir_addr_ready) ||
                       ((r_state == CU_STATE_FETCH_DATA) && i_ir_data_valid);

  control_unit_wait_timer #(
    .LIMIT(FETCH_TIMEOUT)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (!w_in_fetch || w_handshake),
    .i_enable (w_in_fetch),
    .o_expired(w_expired)
  );

  // State, trap cause and retire counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= CU_STATE_IDLE;
      r_trap_cause   <= TRAP_NONE;
      r_retire_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_trap_cause <= w_trap_cause_next;
      if (r_state == CU_STATE_EXEC) begin
        r_retire_count <= r_retire_count + 1'b1;
      end
    end
  end

  // Next-state and control decode; a handshake always beats a same-cycle timeout.
  always_comb begin
    w_next_state      = r_state;
    w_trap_cause_next = r_trap_cause;
    o_ir_addr_valid   = 1'b0;
    o_ir_data_ready   = 1'b0;
    o_ld_inst         = 1'b0;
    o_rs1_en          = 1'b0;
    o_rs2_en          = 1'b0;
    o_rd_en           = 1'b0;
    o_alu_src_sel     = ALU_SRC_RS2;
    o_rd_din_sel      = RD_DIN_ALU;
    o_pc_en           = 1'b0;
    o_pc_next_sel     = PC_NEXT_PLUS4;
    o_retired         = 1'b0;
    o_trap            = 1'b0;
    case (r_state)
      CU_STATE_IDLE: begin
        w_next_state = CU_STATE_FETCH_ADDR;
      end
      CU_STATE_FETCH_ADDR: begin
        o_ir_addr_valid = 1'b1;
        if (i_ir_addr_ready) begin
          w_next_state = CU_STATE_FETCH_DATA;
        end else if (w_expired) begin
          w_next_state      = CU_STATE_TRAP;
          w_trap_cause_next = TRAP_TIMEOUT;
        end
      end
      CU_STATE_FETCH_DATA: begin
        o_ir_data_ready = 1'b1;
        if (i_ir_data_valid) begin
          o_ld_inst    = 1'b1;
          w_next_state = CU_STATE_DECODE;
        end else if (w_expired) begin
          w_next_state      = CU_STATE_TRAP;
          w_trap_cause_next = TRAP_TIMEOUT;
        end
      end
      CU_STATE_DECODE: begin
        if (!inst_type_legal(i_inst_type)) begin
          w_next_state      = CU_STATE_TRAP;
          w_trap_cause_next = TRAP_ILLEGAL;
        end else begin
          o_rs1_en      = w_is_int_imm || w_is_int_reg || w_is_branch;
          o_rs2_en      = w_is_int_reg || w_is_branch;
          o_alu_src_sel = w_is_int_imm ? ALU_SRC_IMM : ALU_SRC_RS2;
          o_rd_din_sel  = w_is_imm ? RD_DIN_IMM : RD_DIN_ALU;
          w_next_state  = CU_STATE_EXEC;
        end
      end
      CU_STATE_EXEC: begin
        o_pc_en       = 1'b1;
        o_retired     = 1'b1;
        o_rd_en       = w_is_imm || w_is_int_imm || w_is_int_reg;
        o_alu_src_sel = w_is_int_imm ? ALU_SRC_IMM : ALU_SRC_RS2;
        o_rd_din_sel  = w_is_imm ? RD_DIN_IMM : RD_DIN_ALU;
        o_pc_next_sel = (w_is_branch && i_branch_taken) ? PC_NEXT_IMM : PC_NEXT_PLUS4;
        w_next_state  = CU_STATE_FETCH_ADDR;
      end
      CU_STATE_TRAP: begin
        o_trap = 1'b1;
      end
      default: begin
        w_next_state = CU_STATE_IDLE;
      end
    endcase
  end

  assign o_retire_count = r_retire_count;
  assign o_trap_cause   = r_trap_cause;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit against a phase-level reference model
module tb_control_unit;
  import control_unit_pkg::*;

  localparam int CW = 4;
  localparam int TO = 5;
  localparam int P_IDLE = 0, P_ADDR = 1, P_DATA = 2, P_DEC = 3, P_EXEC = 4, P_TRAP = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst = 1'b1;
  logic                       ar = 1'b0;
  logic                       dv = 1'b0;
  logic                       bt = 1'b0;
  logic [INST_TYPE_WIDTH-1:0] it = '0;

  logic          o_ir_addr_valid, o_ir_data_ready, o_ld_inst;
  logic          o_rs1_en, o_rs2_en, o_rd_en, o_alu_src_sel, o_rd_din_sel;
  logic          o_pc_en, o_pc_next_sel, o_retired, o_trap;
  logic [CW-1:0] o_retire_count;
  logic [1:0]    o_trap_cause;

  control_unit #(.COUNT_WIDTH(CW), .FETCH_TIMEOUT(TO)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_ir_addr_valid(o_ir_addr_valid),
    .i_ir_addr_ready(ar),
    .i_ir_data_valid(dv),
    .o_ir_data_ready(o_ir_data_ready),
    .o_ld_inst      (o_ld_inst),
    .i_inst_type    (it),
    .i_branch_taken (bt),
    .o_rs1_en       (o_rs1_en),
    .o_rs2_en       (o_rs2_en),
    .o_rd_en        (o_rd_en),
    .o_alu_src_sel  (o_alu_src_sel),
    .o_rd_din_sel   (o_rd_din_sel),
    .o_pc_en        (o_pc_en),
    .o_pc_next_sel  (o_pc_next_sel),
    .o_retired      (o_retired),
    .o_retire_count (o_retire_count),
    .o_trap         (o_trap),
    .o_trap_cause   (o_trap_cause)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase of the instruction we are in, how long we've waited, and counters.
  int m_phase = P_IDLE;
  int m_wait  = 0;
  int m_cause = 0;
  int m_count = 0;
  bit check_en = 1'b0;

  function automatic bit legal(input logic [INST_TYPE_WIDTH-1:0] t);
    return (t >= 1) && (t <= 4);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= P_IDLE; m_wait <= 0; m_cause <= 0; m_count <= 0;
    end else begin
      case (m_phase)
        P_IDLE: begin m_phase <= P_ADDR; m_wait <= 0; end
        P_ADDR:
          if (ar) begin m_phase <= P_DATA; m_wait <= 0; end
          else if (m_wait + 1 == TO) begin m_phase <= P_TRAP; m_cause <= 2; end
          else m_wait <= m_wait + 1;
        P_DATA:
          if (dv) begin m_phase <= P_DEC; m_wait <= 0; end
          else if (m_wait + 1 == TO) begin m_phase <= P_TRAP; m_cause <= 2; end
          else m_wait <= m_wait + 1;
        P_DEC:
          if (!legal(it)) begin m_phase <= P_TRAP; m_cause <= 1; end
          else m_phase <= P_EXEC;
        P_EXEC: begin
          m_count <= (m_count + 1) % (1 << CW);
          m_phase <= P_ADDR;
          m_wait  <= 0;
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : cmp
    bit ok, dec, ex, de;
    #2;
    if (check_en) begin
      ok = legal(it);
      dec = (m_phase == P_DEC) && ok;
      ex  = (m_phase == P_EXEC);
      de  = dec || ex;
      check("ir_addr_valid", o_ir_addr_valid, m_phase == P_ADDR);
      check("ir_data_ready", o_ir_data_ready, m_phase == P_DATA);
      check("ld_inst", o_ld_inst, (m_phase == P_DATA) && dv);
      check("rs1_en", o_rs1_en, dec && (it != INST_TYPE_IMM));
      check("rs2_en", o_rs2_en, dec && (it == INST_TYPE_INT_REG || it == INST_TYPE_BRANCH));
      check("rd_en", o_rd_en, ex && ok && (it != INST_TYPE_BRANCH));
      check("alu_src_sel", o_alu_src_sel, de && (it == INST_TYPE_INT_IMM));
      check("rd_din_sel", o_rd_din_sel, de && (it == INST_TYPE_IMM));
      check("pc_en", o_pc_en, ex);
      check("pc_next_sel", o_pc_next_sel, ex && (it == INST_TYPE_BRANCH) && bt);
      check("retired", o_retired, ex);
      check("retire_count", o_retire_count, m_count);
      check("trap", o_trap, m_phase == P_TRAP);
      check("trap_cause", o_trap_cause, m_cause);
    end
  end

  task automatic drive(input logic r, input logic a, input logic d,
                       input logic [INST_TYPE_WIDTH-1:0] t, input logic b);
    @(negedge clk);
    rst = r; ar = a; dv = d; it = t; bt = b;
  endtask

  logic [INST_TYPE_WIDTH-1:0] seq [4];
  int nav, nld, ret_at, idx, rr;

  initial begin
    seq[0] = INST_TYPE_IMM; seq[1] = INST_TYPE_INT_IMM;
    seq[2] = INST_TYPE_INT_REG; seq[3] = INST_TYPE_BRANCH;

    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    check_en = 1'b1;
    #3;
    check("rst_count", o_retire_count, 0);
    check("rst_trap", o_trap, 0);
    check("rst_addr_valid", o_ir_addr_valid, 0);

    // Zero-wait IMM, INT_IMM, INT_REG, BRANCH(taken): one retire every 4 cycles.
    for (int c = 0; c <= 16; c++) begin
      idx = (c == 0) ? 0 : (c - 1) / 4;
      drive(0, 1, 1, seq[idx], 1);
      #3;
      if (c > 0 && c % 4 == 0) check("zw_retired", o_retired, 1);
      if (c == 16) check("zw_last_pc_next", o_pc_next_sel, 1);
    end

    // Branch not taken.
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 1, INST_TYPE_BRANCH, 0);
      #3;
      if (c == 0) check("zw_count4", o_retire_count, 4);
      if (c == 3) begin
        check("bnt_pc_next", o_pc_next_sel, 0);
        check("bnt_rd_en", o_rd_en, 0);
        check("bnt_pc_en", o_pc_en, 1);
        check("bnt_retired", o_retired, 1);
      end
    end

    // Address ready after 3 waits, data valid after 2 waits: retire on cycle 9.
    nav = 0; nld = 0; ret_at = 0;
    for (int c = 1; c <= 9; c++) begin
      drive(0, c >= 4, c >= 7, INST_TYPE_INT_REG, 1'($urandom));
      #3;
      nav += int'(o_ir_addr_valid);
      nld += int'(o_ld_inst);
      if (o_retired && ret_at == 0) ret_at = c;
    end
    check("wait_addr_valid_cycles", nav, 4);
    check("wait_ld_inst_pulses", nld, 1);
    check("wait_retire_cycle", ret_at, 9);

    // Illegal instruction traps and holds until reset.
    drive(0, 1, 1, INST_TYPE_INT_IMM, 0);
    drive(0, 1, 1, INST_TYPE_INT_IMM, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    #3;
    check("ill_trap", o_trap, 1);
    check("ill_cause", o_trap_cause, 1);
    check("ill_count", o_retire_count, 6);
    for (int c = 0; c < 6; c++) drive(0, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
    #3;
    check("ill_hold", o_trap, 1);

    // Reset inside TRAP.
    drive(1, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    #3;
    check("trst_trap", o_trap, 0);
    check("trst_cause", o_trap_cause, 0);
    check("trst_count", o_retire_count, 0);
    drive(0, 0, 0, 0, 0);
    #3;
    check("trst_resume", o_ir_addr_valid, 1);

    // Data never arrives: timeout trap after 5 cycles in FETCH_DATA.
    drive(0, 1, 0, INST_TYPE_IMM, 0);
    for (int k = 1; k <= 5; k++) drive(0, 0, 0, INST_TYPE_IMM, 0);
    #3;
    check("to_before", o_trap, 0);
    drive(0, 0, 0, INST_TYPE_IMM, 0);
    #3;
    check("to_trap", o_trap, 1);
    check("to_cause", o_trap_cause, 2);

    // Reset while in FETCH_DATA.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, INST_TYPE_INT_REG, 0);
    drive(0, 0, 0, INST_TYPE_INT_REG, 0);
    drive(1, 0, 0, INST_TYPE_INT_REG, 0);
    drive(0, 0, 0, INST_TYPE_INT_REG, 0);
    #3;
    check("frst_addr_valid", o_ir_addr_valid, 0);
    check("frst_data_ready", o_ir_data_ready, 0);
    drive(0, 1, 0, INST_TYPE_INT_REG, 0);
    #3;
    check("frst_resume", o_ir_addr_valid, 1);

    // Handshake on the 5th waiting cycle beats the timeout.
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, k == 5, INST_TYPE_INT_REG, 0);
      #3;
      if (k == 5) check("hs5_ld_inst", o_ld_inst, 1);
    end
    drive(0, 0, 0, INST_TYPE_INT_REG, 0);
    #3;
    check("hs5_no_trap", o_trap, 0);
    check("hs5_decode", o_rs2_en, 1);

    // Retire counter wraps after 16 instructions.
    drive(1, 1, 1, 0, 0);
    for (int c = 0; c <= 65; c++) begin
      drive(0, 1, 1, INST_TYPE_INT_IMM, 0);
      #3;
      if (c == 64) check("wrap_15", o_retire_count, 15);
      if (c == 65) check("wrap_0", o_retire_count, 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0) || (m_phase == P_TRAP && $urandom_range(0, 3) == 0);
      ar  = $urandom_range(0, 9) < 6;
      dv  = $urandom_range(0, 9) < 6;
      bt  = 1'($urandom);
      if (m_phase != P_DEC && m_phase != P_EXEC) begin
        rr = $urandom_range(0, 63);
        if (rr < 60) it = 3'(1 + rr % 4);
        else if (rr == 60) it = 3'd0;
        else it = 3'(rr - 56);
      end
    end

    drive(0, 0, 0, 0, 0);
    #3;
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multicycle sequencer for the copperv core. It fetches each instruction over the instruction-bus handshake and loads it into the instruction register. It then reads the decoder's inst_type and issues the register-file, ALU-operand, writeback and PC-update controls for that instruction. It also counts retired instructions and traps on illegal instructions or a fetch timeout.

Parameters:
COUNT_WIDTH, 32, width of retire_count
FETCH_TIMEOUT, 0, max cycles waiting in a fetch state before trap; 0 = timeout disabled

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
ir_addr_valid  output  1  fetch address request (address = current PC, driven elsewhere)
ir_addr_ready  input  1  instruction bus accepts address
ir_data_valid  input  1  instruction word available
ir_data_ready  output  1  core accepts instruction word
ld_inst  output  1  load instruction register (same cycle as data handshake)
inst_type  input  `INST_TYPE_WIDTH  decoder class of the registered instruction
branch_taken  input  1  branch comparator result
rs1_en  output  1  register-file read port 1 enable
rs2_en  output  1  register-file read port 2 enable
rd_en  output  1  register-file write enable
alu_src_sel  output  1  ALU operand 2: 0 = rs2, 1 = imm
rd_din_sel  output  1  writeback source: 0 = ALU, 1 = imm
pc_en  output  1  update PC
pc_next_sel  output  1  0 = PC+4, 1 = PC+imm
retired  output  1  1-cycle pulse per committed instruction
retire_count  output  COUNT_WIDTH  committed-instruction counter
trap  output  1  core halted
trap_cause  output  2  0 none, 1 illegal instruction, 2 fetch timeout

Behaviour:
- Reset: clk rising edge with rst=1. State goes to IDLE. All outputs are 0, including retire_count and trap_cause.
- Reset mid-fetch drops ir_addr_valid and ir_data_ready on the next cycle. Any in-flight bus transaction is abandoned.
- IDLE: one cycle, then goes to FETCH_ADDR.
- FETCH_ADDR:
  - ir_addr_valid=1.
  - On ir_addr_valid && ir_addr_ready, goes to FETCH_DATA.
  - ir_data_valid is ignored in this state.
- FETCH_DATA:
  - ir_data_ready=1.
  - On ir_data_valid, ld_inst=1 in the same cycle and state goes to DECODE.
- DECODE: one cycle.
  - Illegal is inst_type==0 or any unassigned code. It forces TRAP with cause 1.
  - Otherwise rs1_en=1 for INT_IMM, INT_REG and BRANCH.
  - rs2_en=1 for INT_REG and BRANCH.
  - Next state is EXEC.
- EXEC: one cycle, pc_en=1, retired=1, retire_count increments, then goes to FETCH_ADDR. Per type:
  - IMM: rd_en=1, rd_din_sel=1, pc_next_sel=0.
  - INT_IMM: rd_en=1, rd_din_sel=0, alu_src_sel=1, pc_next_sel=0.
  - INT_REG: rd_en=1, rd_din_sel=0, alu_src_sel=0, pc_next_sel=0.
  - BRANCH: rd_en=0, alu_src_sel=0, pc_next_sel=branch_taken.
- Select stability: alu_src_sel and rd_din_sel are valid in both DECODE and EXEC, and are 0 in all other states.
- Enable scope: rd_en and pc_en are asserted only in EXEC.
- Latency: 4 cycles per instruction with zero-wait bus (FETCH_ADDR, FETCH_DATA, DECODE, EXEC). Each bus wait cycle adds one.
- Fetch timeout:
  - When FETCH_TIMEOUT>0, a wait counter clears on entry to each fetch state.
  - If the counter reaches FETCH_TIMEOUT with no handshake, state goes to TRAP with cause 2.
  - A handshake in the same cycle that the limit is hit wins; no trap occurs.
- TRAP: trap=1. trap_cause holds its value. All enables and valid/ready outputs are 0. Only rst exits TRAP.
- retire_count wraps modulo 2^COUNT_WIDTH with no flag.
- All outputs are registered state decode or combinational from state and inst_type/branch_taken. No combinational path exists from ir_*_ready/valid to ir_*_valid/ready other than ld_inst.

Decomposition:
- copperv_h.v holds the shared constants:
  - INST_TYPE_WIDTH and INST_TYPE_* codes (IMM, INT_IMM, INT_REG, BRANCH).
  - State encodings CU_STATE_*.
  - Trap cause codes TRAP_NONE/ILLEGAL/TIMEOUT.
  - PC_NEXT_* and RD_DIN_* select codes.
- One sub-module is natural: cu_wait_timer (the fetch timeout counter with clear, enable and expired output).

Test Plan:
- Zero-wait bus, instruction sequence IMM, INT_IMM, INT_REG, BRANCH(taken) -> each retires 4 cycles apart; retire_count=4; enables and selects per type in DECODE/EXEC; last pc_next_sel=1.
- BRANCH with branch_taken=0 -> pc_next_sel=0, rd_en=0, pc_en=1, retired=1.
- ir_addr_ready delayed 3 cycles and ir_data_valid delayed 2 cycles -> ir_addr_valid held 4 cycles; instruction retires on cycle 9; ld_inst pulses exactly once.
- inst_type=0 in DECODE -> trap=1, trap_cause=1 next cycle; no rd_en/pc_en; retire_count unchanged; stays trapped until rst.
- FETCH_TIMEOUT=5, ir_data_valid never asserted -> trap_cause=2 after 5 cycles in FETCH_DATA; handshake on the 5th cycle instead -> no trap.
- rst asserted in FETCH_DATA, then in TRAP -> next cycle all outputs 0, state IDLE, retire_count=0; fetch resumes 1 cycle later.
